// File: rtl/regs_file_mp.sv
// Parametrised integer register file: NRD combinational read ports, one core write port,
// a req/ack debug port and a post-reset clear sequence. Optional forwarding: REGS_FILE_BYPASS_EN.
module regs_file_mp #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS),
    parameter int NRD   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  init_done_o,
    input  logic                  wr_en_i,
    input  logic [AW-1:0]         wr_addr_i,
    input  logic [XLEN-1:0]       wr_data_i,
    input  logic [NRD*AW-1:0]     rd_addr_i,
    output logic [NRD*XLEN-1:0]   rd_data_o,
    input  logic                  dbg_req_i,
    input  logic                  dbg_we_i,
    input  logic [AW-1:0]         dbg_addr_i,
    input  logic [XLEN-1:0]       dbg_wdata_i,
    output logic                  dbg_ack_o,
    output logic [XLEN-1:0]       dbg_rdata_o
);

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_IDLE    = 2'd1,
        ST_DBG_ACK = 2'd2
    } state_t;

    localparam logic [AW-1:0]   ADDR_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0]   PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0]   PTR_LAST  = {AW{1'b1}};
    localparam logic [XLEN-1:0] DATA_ZERO = {XLEN{1'b0}};

    logic [XLEN-1:0] mem_r [NREGS];
    state_t          state_r;
    state_t          state_next_s;
    logic [AW-1:0]   ptr_r;
    logic            init_done_r;
    logic            dbg_ack_r;
    logic [XLEN-1:0] dbg_rdata_r;
    logic            req_low_r;
    logic            mem_we_s;
    logic [AW-1:0]   mem_waddr_s;
    logic [XLEN-1:0] mem_wdata_s;
    logic            dbg_accept_s;
    logic [XLEN-1:0] dbg_old_s;

    // Next-state and write-port selection; core writes always win over debug
    always_comb begin
        state_next_s = state_r;
        mem_we_s     = 1'b0;
        mem_waddr_s  = wr_addr_i;
        mem_wdata_s  = wr_data_i;
        dbg_accept_s = 1'b0;
        case (state_r)
            ST_INIT: begin
                mem_we_s    = 1'b1;
                mem_waddr_s = ptr_r;
                mem_wdata_s = DATA_ZERO;
                if (ptr_r == PTR_LAST) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_INIT;
                end
            end
            ST_IDLE: begin
                if (wr_en_i) begin
                    mem_we_s = (wr_addr_i != ADDR_ZERO);
                end else if (dbg_req_i && req_low_r) begin
                    dbg_accept_s = 1'b1;
                    state_next_s = ST_DBG_ACK;
                    mem_we_s     = dbg_we_i && (dbg_addr_i != ADDR_ZERO);
                    mem_waddr_s  = dbg_addr_i;
                    mem_wdata_s  = dbg_wdata_i;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_DBG_ACK: begin
                mem_we_s     = wr_en_i && (wr_addr_i != ADDR_ZERO);
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_INIT;
            end
        endcase
    end

    // Pre-write value of the debug target, captured on accept
    always_comb begin
        if (dbg_addr_i != ADDR_ZERO) begin
            dbg_old_s = mem_r[dbg_addr_i];
        end else begin
            dbg_old_s = DATA_ZERO;
        end
    end

    // FSM state register and clear pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_INIT;
            ptr_r   <= PTR_ONE;
        end else begin
            state_r <= state_next_s;
            if (state_r == ST_INIT) begin
                ptr_r <= ptr_r + PTR_ONE;
            end
        end
    end

    // Registered status/debug outputs and the re-arm flag for held requests
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_done_r <= 1'b0;
            dbg_ack_r   <= 1'b0;
            dbg_rdata_r <= DATA_ZERO;
            req_low_r   <= 1'b1;
        end else begin
            init_done_r <= (state_next_s != ST_INIT);
            dbg_ack_r   <= (state_next_s == ST_DBG_ACK);
            if (dbg_accept_s) begin
                dbg_rdata_r <= dbg_old_s;
                req_low_r   <= 1'b0;
            end else if (!dbg_req_i) begin
                req_low_r   <= 1'b1;
            end
        end
    end

    // Storage array: deliberately not reset, the clear sequence owns initialisation
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_waddr_s] <= mem_wdata_s;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   addr_s;
        logic [XLEN-1:0] word_s;
        assign addr_s = rd_addr_i[k*AW +: AW];

        // Read mux for port k; zero while clearing and for register 0
        always_comb begin
            if (!init_done_r || (addr_s == ADDR_ZERO)) begin
                word_s = DATA_ZERO;
`ifdef REGS_FILE_BYPASS_EN
            end else if (wr_en_i && (wr_addr_i == addr_s)) begin
                word_s = wr_data_i;
`endif
            end else begin
                word_s = mem_r[addr_s];
            end
        end

        assign rd_data_o[k*XLEN +: XLEN] = word_s;
    end

    assign init_done_o = init_done_r;
    assign dbg_ack_o   = dbg_ack_r;
    assign dbg_rdata_o = dbg_rdata_r;

endmodule

// File: doc/regs_file_mp.md
Name: regs_file_mp

Overview:
- Parametrised successor to the core integer register file.
- Configurable data width, register count and number of combinational read ports.
- Hardware clear sequence after reset, so no register holds X.
- Debug port with req/ack handshake, arbitrated against the core write port.
- Sits between decode (read ports), writeback (write port) and the JTAG debug module (debug port).

Parameters:
- XLEN, 32, register data width in bits.
- NREGS, 32, number of architectural registers; power of two, >= 4. Register 0 is hardwired zero.
- AW, $clog2(NREGS), register address width (derived; do not override).
- NRD, 2, number of read ports (1..4).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- init_done_o  output  1  high once the post-reset clear sequence has finished.
- wr_en_i  input  1  core write enable.
- wr_addr_i  input  AW  core write address.
- wr_data_i  input  XLEN  core write data.
- rd_addr_i  input  NRD*AW  read addresses; port k uses bits [k*AW +: AW].
- rd_data_o  output  NRD*XLEN  read data; port k uses bits [k*XLEN +: XLEN].
- dbg_req_i  input  1  debug access request; held high until ack.
- dbg_we_i  input  1  debug write (1) / read (0); stable while req is high.
- dbg_addr_i  input  AW  debug address; stable while req is high.
- dbg_wdata_i  input  XLEN  debug write data; stable while req is high.
- dbg_ack_o  output  1  one-cycle completion pulse.
- dbg_rdata_o  output  XLEN  registered debug read data; valid while dbg_ack_o is high, held afterwards.

Behaviour:
- Reset (async, rst_n low):
  - FSM goes to INIT; clear pointer = 1.
  - init_done_o = 0, dbg_ack_o = 0, dbg_rdata_o = 0.
  - Register array is not reset directly.
- FSM states: INIT, IDLE, DBG_ACK.
- INIT:
  - Each cycle writes 0 to register[ptr], then ptr++.
  - After writing NREGS-1, go to IDLE and set init_done_o = 1 on the next edge. Total NREGS-1 cycles after rst_n release.
  - Core writes are ignored, dbg_req_i is not accepted, and all rd_data_o ports read 0.
- IDLE:
  - Core write: if wr_en_i && wr_addr_i != 0, register[wr_addr_i] <= wr_data_i at posedge.
  - Debug request accepted only when dbg_req_i = 1 and wr_en_i = 0 (core has priority); otherwise the request waits, with no timeout.
  - On accept: if dbg_we_i && dbg_addr_i != 0, write dbg_wdata_i. Capture dbg_rdata_o = pre-write value of register[dbg_addr_i] (0 for addr 0). Go to DBG_ACK.
- DBG_ACK:
  - dbg_ack_o = 1 for exactly this cycle. Core writes proceed normally.
  - Next state is IDLE. A request still high after ack is treated as a new request only after dbg_req_i has been seen low for at least 1 cycle; track this with a req-seen-low flag.
- Reads:
  - Purely combinational.
  - Address 0 returns 0.
  - Without bypass, a same-cycle write is not visible until the next cycle.
- Writes to address 0 from any source are discarded.
- rst_n asserted mid-debug transaction: FSM returns to INIT, no ack is issued, and the requester must re-issue after init_done_o.
- Port ordering is fixed: port k's data depends only on port k's address.

Optional Feature:
- Macro: REGS_FILE_BYPASS_EN.
- Defined: for each read port, if init_done_o && wr_en_i && wr_addr_i == rd_addr && rd_addr != 0, rd_data_o returns wr_data_i in the same cycle (write-to-read forwarding). Debug writes are not forwarded.
- Undefined: no forwarding. Reads always return the array contents.

Test Plan:
- Release rst_n, hold wr_en_i = 1 throughout -> init_done_o rises exactly 31 cycles after release (NREGS = 32), no register written by core during INIT, all rd_data_o = 0 after init.
- After init, write x5 = 0xDEADBEEF, then read port 0 addr 5 and port 1 addr 0 -> 0xDEADBEEF and 0x00000000. Write x0 = 0x1234 -> port 0 addr 0 still 0.
- Same-cycle write x7 = 0xA5A5A5A5 with read addr 7: without macro, old value (0) that cycle, 0xA5A5A5A5 next cycle; with REGS_FILE_BYPASS_EN, 0xA5A5A5A5 in the same cycle.
- dbg_req_i with dbg_we_i = 1, addr 3, data 0x55, while wr_en_i is high for 3 cycles -> no ack during those cycles; ack 1 cycle after wr_en_i drops; dbg_rdata_o = old x3; x3 = 0x55 afterwards.
- Debug read addr 5 (held 0xDEADBEEF), req kept high after ack -> single ack pulse, dbg_rdata_o = 0xDEADBEEF; second ack only after req toggles low then high.
- Assert rst_n low while a debug request is pending -> dbg_ack_o = 0 and init_done_o = 0 immediately; INIT reruns; register 5 reads 0 after init_done_o.
